// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg : shared entry layout and error-bit indices for the RX frame FIFO
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  localparam int RX_DATA_WIDTH = 8;

  // Flag bits sit above the data byte; rd_err is the top two bits of an entry
  typedef struct packed {
    logic                     stop_err;
    logic                     parity_err;
    logic [RX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

endpackage

`default_nettype wire

// File: rtl/rx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo_if : receiver write strobe, consumer handshake and status
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rx_frame_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_err;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  overflow;
  logic                  ovf_clr;
  logic                  err_drop;

  modport master (
    output p_data, data_valid, parity_error, stop_error, rd_ready, ovf_clr,
    input  rd_data, rd_err, rd_valid, count, full, overflow, err_drop
  );

  modport slave (
    input  p_data, data_valid, parity_error, stop_error, rd_ready, ovf_clr,
    output rd_data, rd_err, rd_valid, count, full, overflow, err_drop
  );

endinterface

`default_nettype wire

// File: rtl/rx_fifo_ptr.sv
// ---------------------------------------------------------------------------
// rx_fifo_ptr : FIFO pointer with increment enable, one extra wrap bit
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_fifo_ptr #(
  parameter int ADDR_WIDTH = 3
) (
  input  wire logic                rx_clk,
  input  wire logic                rst,
  input  wire logic                inc_i,
  output logic      [ADDR_WIDTH:0] ptr_o
);

  localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] ptr_q;
  logic [ADDR_WIDTH:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + C_ONE;
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo : FWFT buffer for received UART frames and their error flags.
//                 RX_FIFO_DROP_ERR_EN: discard errored frames, pulse err_drop.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_frame_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input wire logic         rx_clk,
  input wire logic         rst,
  rx_frame_fifo_if.slave   bus
);

  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                overflow_q;
  logic                overflow_d;
  logic                empty;
  logic                full;
  logic                rd_fire;
  logic                frame_err;
  logic                wr_ok;
  logic                wr_accept;
  logic                ovf_set;
  logic [EW-1:0]       wr_entry;
  logic [EW-1:0]       head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
  assign rd_fire   = !empty && bus.rd_ready;
  assign frame_err = bus.parity_error || bus.stop_error;

`ifdef RX_FIFO_DROP_ERR_EN
  logic err_drop_q;

  assign wr_ok = bus.data_valid && !frame_err;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) err_drop_q <= 1'b0;
    else     err_drop_q <= bus.data_valid && frame_err;
  end

  assign bus.err_drop = err_drop_q;
`else
  assign wr_ok        = bus.data_valid;
  assign bus.err_drop = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_accept = wr_ok && (!full || rd_fire);
  assign ovf_set   = wr_ok && full && !rd_fire;

  always_comb begin
    wr_entry                         = '0;
    wr_entry[DATA_WIDTH-1:0]         = bus.p_data;
    wr_entry[DATA_WIDTH+ERR_PARITY]  = bus.parity_error;
    wr_entry[DATA_WIDTH+ERR_STOP]    = bus.stop_error;
  end

  rx_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .rx_clk (rx_clk),
    .rst    (rst),
    .inc_i  (wr_accept),
    .ptr_o  (wr_ptr)
  );

  rx_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .rx_clk (rx_clk),
    .rst    (rst),
    .inc_i  (rd_fire),
    .ptr_o  (rd_ptr)
  );

  // Storage is cleared on reset so the FWFT head reads 0 while empty after reset
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_accept) begin
      mem_q[wr_ptr[ADDR_WIDTH-1:0]] <= wr_entry;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (ovf_set)     overflow_d = 1'b1;
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign head         = mem_q[rd_ptr[ADDR_WIDTH-1:0]];
  assign bus.rd_data  = head[DATA_WIDTH-1:0];
  assign bus.rd_err   = head[EW-1:DATA_WIDTH];
  assign bus.rd_valid = !empty;
  assign bus.count    = wr_ptr - rd_ptr;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_fifo : directed self-checking bench for rx_frame_fifo
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_frame_fifo;
  import uart_rx_pkg::*;

  logic rx_clk = 1'b0;
  logic rst    = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  rx_frame_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bif ();

  rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (bif.slave)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bif.p_data     = d;
    bif.data_valid = 1'b1;
    tick();
    bif.data_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, {24'd0, bif.rd_data}, {24'd0, d});
    bif.rd_ready = 1'b1;
    tick();
    bif.rd_ready = 1'b0;
  endtask

  rx_entry_t exp_e;

  initial begin
    bif.p_data       = '0;
    bif.data_valid   = 1'b0;
    bif.parity_error = 1'b0;
    bif.stop_error   = 1'b0;
    bif.rd_ready     = 1'b0;
    bif.ovf_clr      = 1'b0;

    tick();
    tick();
    check("rst_rd_valid", {31'd0, bif.rd_valid}, 32'd0);
    check("rst_count",    {28'd0, bif.count},    32'd0);
    check("rst_full",     {31'd0, bif.full},     32'd0);
    check("rst_overflow", {31'd0, bif.overflow}, 32'd0);
    check("rst_rd_data",  {24'd0, bif.rd_data},  32'd0);
    check("rst_err_drop", {31'd0, bif.err_drop}, 32'd0);
    rst = 1'b0;
    tick();

    // single frame, one-cycle latency
    push(8'hA5);
    check("t1_rd_valid", {31'd0, bif.rd_valid}, 32'd1);
    check("t1_rd_data",  {24'd0, bif.rd_data},  32'hA5);
    check("t1_rd_err",   {30'd0, bif.rd_err},   32'd0);
    check("t1_count",    {28'd0, bif.count},    32'd1);
    pop_expect("t1_pop", 8'hA5);
    check("t1_empty_count", {28'd0, bif.count}, 32'd0);

    // fill then drain in order
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("t2_full",  {31'd0, bif.full},  32'd1);
    check("t2_count", {28'd0, bif.count}, 32'd8);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("t2_drain%0d", i), 8'(i));
    check("t2_count0",   {28'd0, bif.count},    32'd0);
    check("t2_rd_valid", {31'd0, bif.rd_valid}, 32'd0);

    // overflow on full, clear, then set-wins-over-clear
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    push(8'hFF);
    check("t3_overflow", {31'd0, bif.overflow}, 32'd1);
    check("t3_count",    {28'd0, bif.count},    32'd8);
    bif.ovf_clr = 1'b1;
    tick();
    bif.ovf_clr = 1'b0;
    check("t3_ovf_clr", {31'd0, bif.overflow}, 32'd0);
    bif.ovf_clr = 1'b1;
    push(8'hFF);
    bif.ovf_clr = 1'b0;
    check("t3_set_wins", {31'd0, bif.overflow}, 32'd1);
    bif.ovf_clr = 1'b1;
    tick();
    bif.ovf_clr = 1'b0;

    // full with simultaneous write and read
    check("t4_head", {24'd0, bif.rd_data}, 32'h11);
    bif.rd_ready = 1'b1;
    push(8'h55);
    bif.rd_ready = 1'b0;
    check("t4_count", {28'd0, bif.count}, 32'd8);
    check("t4_full",  {31'd0, bif.full},  32'd1);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("t4_drain%0d", i), 8'h11 + 8'(i));
    pop_expect("t4_last", 8'h55);
    check("t4_empty", {31'd0, bif.rd_valid}, 32'd0);

    // empty with write and rd_ready: write only
    bif.rd_ready = 1'b1;
    push(8'h77);
    bif.rd_ready = 1'b0;
    check("t5_count", {28'd0, bif.count}, 32'd1);
    pop_expect("t5_pop", 8'h77);

    // errored frames
    bif.parity_error = 1'b1;
    push(8'h3C);
    bif.parity_error = 1'b0;
`ifdef RX_FIFO_DROP_ERR_EN
    check("t6_err_drop", {31'd0, bif.err_drop}, 32'd1);
    check("t6_count",    {28'd0, bif.count},    32'd0);
    tick();
    check("t6_drop_end", {31'd0, bif.err_drop}, 32'd0);
    check("t6_ovf",      {31'd0, bif.overflow}, 32'd0);
`else
    exp_e = '{stop_err: 1'b0, parity_err: 1'b1, data: 8'h3C};
    check("t6_count",    {28'd0, bif.count},  32'd1);
    check("t6_rd_err",   {30'd0, bif.rd_err}, {30'd0, exp_e.stop_err, exp_e.parity_err});
    check("t6_err_drop", {31'd0, bif.err_drop}, 32'd0);
    pop_expect("t6_pop", exp_e.data);
    bif.stop_error = 1'b1;
    push(8'hC3);
    bif.stop_error = 1'b0;
    check("t6_stop_err", {30'd0, bif.rd_err}, 32'd2);
    pop_expect("t6_pop2", 8'hC3);
`endif

    // asynchronous reset mid-operation with 4 entries and overflow set
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    push(8'hEE);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("t7_pop%0d", i), 8'h20 + 8'(i));
    check("t7_count4", {28'd0, bif.count},    32'd4);
    check("t7_ovf1",   {31'd0, bif.overflow}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_count",    {28'd0, bif.count},    32'd0);
    check("t7_rd_valid", {31'd0, bif.rd_valid}, 32'd0);
    check("t7_rd_data",  {24'd0, bif.rd_data},  32'd0);
    check("t7_overflow", {31'd0, bif.overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(8'h9A);
    check("t8_rd_data", {24'd0, bif.rd_data}, 32'h9A);
    check("t8_count",   {28'd0, bif.count},   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_frame_fifo.md
# rx_frame_fifo

Receive-side frame buffer that sits directly downstream of the UART receiver. It captures each received byte together with its parity and stop error flags on the receiver's `data_valid` strobe, and holds them in a first-word-fall-through FIFO. The consumer (a bus interface or core logic) drains it with a valid/ready handshake, so back-to-back frames are not lost while the consumer is busy.

## Interface
- `DATA_WIDTH`, 8, width of `p_data` and `rd_data`.
- `DEPTH`, 8, number of entries; must be a power of two, minimum 2.
- `ADDR_WIDTH`, $clog2(DEPTH), pointer index width.

Ports:
- `rx_clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `p_data` in DATA_WIDTH: received byte from the receiver.
- `data_valid` in 1: write strobe; each cycle it is high is one frame.
- `parity_error` in 1: sampled together with `p_data`.
- `stop_error` in 1: sampled together with `p_data`.
- `rd_data` out DATA_WIDTH: head-entry byte.
- `rd_err` out 2: head-entry flags, {stop_error, parity_error}.
- `rd_valid` out 1: head entry is present (FIFO not empty).
- `rd_ready` in 1: consumer accepts the head entry when `rd_valid` && `rd_ready`.
- `count` out ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `full` out 1: `count` == DEPTH.
- `overflow` out 1: sticky flag, set when a frame is lost because the FIFO is full.
- `ovf_clr` in 1: synchronous clear of `overflow`.
- `err_drop` out 1: one-cycle pulse when an errored frame is discarded (see Configuration).

## Operation
- Storage is an array of DEPTH entries, each DATA_WIDTH+2 bits wide.
- Read and write pointers are ADDR_WIDTH+1 bits; the MSB distinguishes full from empty.
  - empty: pointers are equal.
  - full: pointers differ only in the MSB.
- Pointers wrap naturally modulo 2·DEPTH.
- Write accept condition: `data_valid` && (!full || read fire this cycle).
  - On accept, the entry is stored at the write pointer and the write pointer increments.
- Read fire condition: `rd_valid` && `rd_ready`. The read pointer increments.
- `rd_data`/`rd_err` are driven combinationally from the entry at the read pointer (first-word fall-through).
- `count` = write pointer − read pointer, in ADDR_WIDTH+1 bits.
- Simultaneous events:
  - Full with write and read in the same cycle: both occur; `count` stays at DEPTH.
  - Empty with write and `rd_ready` high: no read (`rd_valid` is low), the write is stored, `count` becomes 1.
  - Full with write and no read: the frame is discarded, pointers are unchanged, `overflow` is set.
  - `ovf_clr` in the same cycle as a new overflow: set wins.
- Reset, including mid-operation:
  - Pointers, `overflow` and the storage array all go to 0.
  - Output values in reset: `rd_valid`=0, `rd_data`=0, `rd_err`=0, `count`=0, `full`=0, `overflow`=0, `err_drop`=0.
  - Frames in flight are lost.
- The block has no state machine beyond the pointer pair and the sticky flag.

## Timing
- Write-to-read latency is 1 cycle: a frame strobed at edge N gives `rd_valid`=1 and the new data visible after edge N.
- `count`, `full` and `rd_valid` update after the edge on which the write or read occurs.
- `rd_data` changes to the next entry in the cycle following a read fire.
- Sustained throughput is 1 write and 1 read per cycle.
- `overflow` asserts after the edge of the lost write.
- `err_drop` is high for exactly the cycle after the discarded strobe (registered).

## Configuration
- Macro: `RX_FIFO_DROP_ERR_EN`.
- Defined:
  - A strobe with `parity_error` or `stop_error` high is not written.
  - `err_drop` pulses for one cycle.
  - `overflow` is not affected by a dropped errored frame.
  - Stored `rd_err` is therefore always 0.
- Undefined:
  - Errored frames are stored with their flags in `rd_err`.
  - `err_drop` is tied to 0.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the entry typedef `rx_entry_t` {stop_err, parity_err, data[DATA_WIDTH-1:0]};
  - the `rd_err` bit-index constants `ERR_PARITY`=0 and `ERR_STOP`=1.
- One sub-module, `rx_fifo_ptr`: pointer register with increment enable and wrap, instantiated for the read and write sides.
- Full/empty/count logic lives in the top level.

## Test plan
- Reset, then write 0xA5 with both flags 0 → next cycle `rd_valid`=1, `rd_data`=0xA5, `rd_err`=0, `count`=1.
- Write 8 frames 0x01..0x08 with `rd_ready`=0 → `full`=1, `count`=8; then drain → data read out in order 0x01..0x08, `count` returns to 0, `rd_valid`=0.
- Full FIFO, strobe 0xFF with `rd_ready`=0 → `overflow`=1, `count` stays 8, 0xFF is never read; pulse `ovf_clr` → `overflow`=0.
- Full FIFO, strobe 0x55 with `rd_ready`=1 in the same cycle → head popped, 0x55 stored, `count` stays 8, 0x55 is read out last.
- Strobe 0x3C with `parity_error`=1:
  - macro undefined → stored with `rd_err`=2'b01;
  - macro defined → `err_drop` pulses, `count` stays 0.
- Fill with 4 entries, assert `rst` mid-cycle asynchronously → `count`=0, `rd_valid`=0, `rd_data`=0, `overflow`=0 immediately, without waiting for a clock edge.
